// File: rtl/ws_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ws_bit_sequencer
// Description : Turns a byte stream into a WS281X single-wire serial waveform.
//               Each byte is sent MSB first. Every bit lasts BIT_CLKS clocks.
//               The bit is high for T1H_CLKS (bit=1) or T0H_CLKS (bit=0) and
//               low for the rest. A LATCH_CLKS low gap follows the last byte
//               of a frame.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous, active-high; clears all state
//   Data[7:0] in   byte to send, MSB first
//   Last      in   Data is the final byte of the frame
//   Valid     in   Data/Last valid
//   Ready     out  block accepts Data this cycle
//   Dout      out  registered serial waveform
//   Busy      out  sequencer not idle
//   Done      out  one-cycle pulse at the end of the latch gap
//   Underrun  out  sticky: byte stream ran dry mid-frame
// Build option
//   WS_UNDERRUN_LATCH_EN : when defined, an underrun ends the frame with a
//                          normal latch gap and Done pulse. When undefined,
//                          an underrun returns straight to idle.
// ============================================================================
module ws_bit_sequencer #(
  parameter int BIT_CLKS   = 25,
  parameter int T0H_CLKS   = 7,
  parameter int T1H_CLKS   = 14,
  parameter int LATCH_CLKS = 1000,
  parameter int CNT_WIDTH  = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Data,
  input  logic       Last,
  input  logic       Valid,
  output logic       Ready,
  output logic       Dout,
  output logic       Busy,
  output logic       Done,
  output logic       Underrun
);

  // Elaboration-time parameter checks
  if (!((T0H_CLKS > 0) && (T0H_CLKS < T1H_CLKS) && (T1H_CLKS < BIT_CLKS))) begin : g_bad_timing
    $error("ws_bit_sequencer: require 0 < T0H_CLKS < T1H_CLKS < BIT_CLKS");
  end
  if ((LATCH_CLKS < 1) || (BIT_CLKS > (2 ** CNT_WIDTH)) || (LATCH_CLKS > (2 ** CNT_WIDTH))) begin : g_bad_width
    $error("ws_bit_sequencer: CNT_WIDTH too small for BIT_CLKS/LATCH_CLKS");
  end

  // Terminal counts (counter runs 0 .. N-1)
  localparam logic [CNT_WIDTH-1:0] c_bit_last   = CNT_WIDTH'(BIT_CLKS - 1);
  localparam logic [CNT_WIDTH-1:0] c_t0h_last   = CNT_WIDTH'(T0H_CLKS - 1);
  localparam logic [CNT_WIDTH-1:0] c_t1h_last   = CNT_WIDTH'(T1H_CLKS - 1);
  localparam logic [CNT_WIDTH-1:0] c_latch_last = CNT_WIDTH'(LATCH_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t               r_state,    w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt,      w_cnt_nxt;
  logic [2:0]           r_idx,      w_idx_nxt;
  logic [7:0]           r_data,     w_data_nxt;
  logic                 r_last,     w_last_nxt;
  logic                 r_underrun, w_underrun_nxt;
  logic                 r_done,     w_done_nxt;
  logic                 r_dout;
  logic                 w_ready;
  logic [CNT_WIDTH-1:0] w_high_last;

  // The bit counter spans the whole bit period; HIGH ends at the per-bit
  // high time and LOW runs on to the common bit end, so every bit has the
  // same length regardless of its value.
  assign w_high_last = r_data[r_idx] ? c_t1h_last : c_t0h_last;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_last     <= 1'b0;
      r_underrun <= 1'b0;
      r_done     <= 1'b0;
      r_dout     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_data     <= w_data_nxt;
      r_last     <= w_last_nxt;
      r_underrun <= w_underrun_nxt;
      r_done     <= w_done_nxt;
      // The pin follows the state one clock later, so the first high clock
      // is the one after the transfer edge.
      r_dout     <= (r_state == ST_HIGH);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_data_nxt     = r_data;
    w_last_nxt     = r_last;
    w_underrun_nxt = r_underrun;
    w_done_nxt     = 1'b0;
    w_ready        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (Valid) begin
          w_data_nxt  = Data;
          w_last_nxt  = Last;
          w_idx_nxt   = 3'd7;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HIGH;
        end
      end

      ST_HIGH: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == w_high_last) begin
          w_state_nxt = ST_LOW;
        end
      end

      ST_LOW: begin
        if (r_cnt == c_bit_last) begin
          w_cnt_nxt = '0;
          if (r_idx != 3'd0) begin
            w_idx_nxt   = r_idx - 3'd1;
            w_state_nxt = ST_HIGH;
          end else if (r_last) begin
            w_state_nxt = ST_LATCH;
          end else begin
            // Final clock of the byte: accept the next byte with no gap.
            w_ready = 1'b1;
            if (Valid) begin
              w_data_nxt  = Data;
              w_last_nxt  = Last;
              w_idx_nxt   = 3'd7;
              w_state_nxt = ST_HIGH;
            end else begin
              w_underrun_nxt = 1'b1;
`ifdef WS_UNDERRUN_LATCH_EN
              w_state_nxt    = ST_LATCH;
`else
              w_state_nxt    = ST_IDLE;
`endif
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_LATCH: begin
        if (r_cnt == c_latch_last) begin
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign Ready    = w_ready;
  assign Dout     = r_dout;
  assign Busy     = (r_state != ST_IDLE);
  assign Done     = r_done;
  assign Underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ws_bit_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws_bit_sequencer
// Description : Self-checking bench for ws_bit_sequencer. Single-byte frames
//               come from a vector table. Hand-written sequences cover
//               back-to-back bytes, underrun, reset mid-bit and Data changes
//               while not ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws_bit_sequencer;

  localparam int BIT   = 25;
  localparam int T0H   = 7;
  localparam int T1H   = 14;
  localparam int LATCH = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       last;
  logic       valid;
  logic       ready;
  logic       dout;
  logic       busy;
  logic       done;
  logic       underrun;

  int n_checks = 0;
  int n_fail   = 0;

  ws_bit_sequencer #(
    .BIT_CLKS  (BIT),
    .T0H_CLKS  (T0H),
    .T1H_CLKS  (T1H),
    .LATCH_CLKS(LATCH),
    .CNT_WIDTH (10)
  ) dut (
    .Clock   (clk),
    .Reset   (rst),
    .Data    (data),
    .Last    (last),
    .Valid   (valid),
    .Ready   (ready),
    .Dout    (dout),
    .Busy    (busy),
    .Done    (done),
    .Underrun(underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Presents a byte, checks Ready,
  // and returns at the negedge after the transfer edge (cycle 0 of the byte).
  task automatic start_frame(input logic [7:0] d, input logic l, input bit keep_valid, input string tag);
    data  = d;
    last  = l;
    valid = 1'b1;
    check({tag, " ready in idle"}, ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) valid = 1'b0;
    check({tag, " dout low on transfer cycle"}, dout, 0);
    check({tag, " busy after transfer"}, busy, 1);
  endtask

  // Samples the 200 Dout clocks of one byte (sample k = 1..200 after the
  // byte's transfer edge) and checks each bit's high time and shape.
  task automatic run_byte(input logic [7:0] exp_bits, input string tag,
                          output int ready_cnt, output int ready_pos, output int hi_total);
    int hi;
    int k;
    bit shape_ok;
    bit busy_ok;
    ready_cnt = 0;
    ready_pos = -1;
    hi_total  = 0;
    busy_ok   = 1'b1;
    for (int j = 0; j < 8; j++) begin
      hi       = 0;
      shape_ok = 1'b1;
      for (int c = 1; c <= BIT; c++) begin
        @(negedge clk);
        k = j * BIT + c;
        if (dout) begin
          if (c != hi + 1) shape_ok = 1'b0;
          hi++;
        end
        if (k < 8 * BIT) begin
          if (ready) begin
            ready_cnt++;
            ready_pos = k + 1;   // 1-based clock number within the byte
          end
          if (!busy) busy_ok = 1'b0;
        end
      end
      check($sformatf("%s bit%0d high clks", tag, 7 - j), hi, exp_bits[7 - j] ? T1H : T0H);
      check($sformatf("%s bit%0d shape", tag, 7 - j), shape_ok, 1);
      hi_total += hi;
    end
    check({tag, " busy through byte"}, busy_ok, 1);
  endtask

  // Starts at sample 200 of the final byte. Checks the low gap and Done.
  task automatic run_latch(input string tag);
    bit gap_ok;
    gap_ok = 1'b1;
    for (int k = 201; k < 200 + LATCH; k++) begin
      @(negedge clk);
      if (dout || done || !busy || ready) gap_ok = 1'b0;
    end
    check({tag, " latch gap low/busy/no done"}, gap_ok, 1);
    @(negedge clk);
    check({tag, " done pulse"}, done, 1);
    check({tag, " busy clear at done"}, busy, 0);
    check({tag, " dout low at done"}, dout, 0);
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;      // order on the wire, MSB first
    int         exp_hi_total;  // total high clocks across the byte
  } vec_t;

  vec_t vecs[4];

  initial begin
    int rc, rp, ht, ht2;
    bit quiet_ok;

    vecs[0] = '{8'hA5, 8'b1010_0101, 84};
    vecs[1] = '{8'h00, 8'b0000_0000, 56};
    vecs[2] = '{8'hFF, 8'b1111_1111, 112};
    vecs[3] = '{8'h3C, 8'b0011_1100, 84};

    rst   = 1'b1;
    data  = 8'h00;
    last  = 1'b0;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset dout", dout, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset underrun", underrun, 0);
    rst = 1'b0;
    check("after reset ready", ready, 1);

    // Single-byte frames, first one transfers on the first edge after reset
    for (int v = 0; v < 4; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      start_frame(vecs[v].data, 1'b1, 1'b0, tag);
      run_byte(vecs[v].exp_bits, tag, rc, rp, ht);
      check({tag, " no ready mid-byte"}, rc, 0);
      check({tag, " high total"}, ht, vecs[v].exp_hi_total);
      run_latch(tag);
      check({tag, " underrun clear"}, underrun, 0);
    end

    // Back-to-back FF then 00 (Last), Valid held across the first byte
    start_frame(8'hFF, 1'b0, 1'b1, "b2b");
    data = 8'h00;
    last = 1'b1;
    run_byte(8'hFF, "b2b byte1", rc, rp, ht);
    valid = 1'b0;
    check("b2b ready pulses", rc, 1);
    check("b2b ready position", rp, 200);
    run_byte(8'h00, "b2b byte2", rc, rp, ht2);
    check("b2b byte2 no ready", rc, 0);
    check("b2b high total", ht + ht2, 168);
    run_latch("b2b");

    // Underrun: one byte with Last clear and nothing after
    start_frame(8'h80, 1'b0, 1'b0, "urun");
    run_byte(8'h80, "urun", rc, rp, ht);
    check("urun ready offered", rc, 1);
    check("urun underrun set", underrun, 1);
`ifdef WS_UNDERRUN_LATCH_EN
    check("urun busy into latch", busy, 1);
    run_latch("urun");
`else
    check("urun idle at once", busy, 0);
    check("urun no done", done, 0);
    quiet_ok = 1'b1;
    for (int k = 0; k < LATCH + 20; k++) begin
      @(negedge clk);
      if (done || dout || busy) quiet_ok = 1'b0;
    end
    check("urun quiet idle", quiet_ok, 1);
`endif
    check("urun sticky", underrun, 1);

    // Valid held mid-byte with changing Data; only the Ready-cycle byte goes
    start_frame(8'h96, 1'b0, 1'b1, "hold");
    fork
      run_byte(8'h96, "hold byte1", rc, rp, ht);
      begin
        repeat (149) begin
          @(negedge clk);
          data = 8'($urandom);
          last = 1'($urandom);
        end
        @(negedge clk);
        data = 8'h5A;
        last = 1'b1;
        repeat (50) @(negedge clk);
        valid = 1'b0;
      end
    join
    check("hold ready pulses", rc, 1);
    check("hold ready position", rp, 200);
    run_byte(8'h5A, "hold byte2", rc, rp, ht);
    run_latch("hold");
    check("hold underrun still sticky", underrun, 1);

    // Reset during the HIGH phase of bit 3 (5th bit on the wire)
    start_frame(8'hFF, 1'b1, 1'b0, "rst");
    repeat (4 * BIT + 5) @(negedge clk);
    check("rst dout high before reset", dout, 1);
    rst = 1'b1;
    #1;
    check("rst dout async clear", dout, 0);
    check("rst busy async clear", busy, 0);
    check("rst underrun async clear", underrun, 0);
    check("rst done async clear", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_frame(8'h01, 1'b1, 1'b0, "post");
    run_byte(8'h01, "post", rc, rp, ht);
    check("post high total", ht, 63);
    run_latch("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
